// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte-stream input and RAM port A write bus of the program loader
interface program_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dia;

    modport master (
        output in_valid, in_data,
        input  in_ready, ena, wea, addra, dia
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ena, wea, addra, dia
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream loader that fills program RAM and releases the CPU
module program_loader #(
    parameter int         ADDR_W    = 10,
    parameter int         DATA_W    = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic clka,
    input  logic rst,
    program_loader_if.slave bus,
    output logic busy,
    output logic done,
    output logic error,
    output logic cpu_rst
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
        S_DATA_H, S_DATA_L, S_WRITE, S_CHK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] CNT_MAX = 17'(2 ** ADDR_W);

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_hi;
    logic [7:0]        r_chk;
    logic [15:0]       r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_dia;
    logic              w_ready;
    logic              w_accept;
    logic [15:0]       w_word;

    // in_ready is gated by rst directly so it drops the moment reset asserts
    assign w_ready  = (r_state != S_WRITE) && !rst;
    assign w_accept = bus.in_valid && w_ready;
    assign w_word   = {r_hi, bus.in_data};

    assign bus.in_ready = w_ready;
    assign bus.ena      = (r_state == S_WRITE);
    assign bus.wea      = (r_state == S_WRITE);
    assign bus.addra    = r_addra;
    assign bus.dia      = r_dia;

    assign busy    = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign done    = (r_state == S_DONE);
    assign error   = (r_state == S_ERROR);
    assign cpu_rst = (r_state != S_DONE);

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (w_accept && bus.in_data == SYNC_BYTE) w_next = S_ADDR_H;
            S_ADDR_H: if (w_accept) w_next = S_ADDR_L;
            S_ADDR_L: if (w_accept) w_next = S_CNT_H;
            S_CNT_H:  if (w_accept) w_next = S_CNT_L;
            S_CNT_L: begin
                if (w_accept) begin
                    if ({1'b0, w_word} > CNT_MAX)  w_next = S_ERROR;
                    else if (w_word == 16'd0)      w_next = S_CHK;
                    else                           w_next = S_DATA_H;
                end
            end
            S_DATA_H: if (w_accept) w_next = S_DATA_L;
            S_DATA_L: if (w_accept) w_next = S_WRITE;
            S_WRITE:  w_next = (r_cnt == 16'd1) ? S_CHK : S_DATA_H;
            S_CHK: begin
                if (w_accept) w_next = (bus.in_data == r_chk) ? S_DONE : S_ERROR;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_hi    <= '0;
            r_chk   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_addra <= '0;
            r_dia   <= '0;
        end else if (r_state == S_WRITE) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 16'd1;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: if (bus.in_data == SYNC_BYTE) r_chk <= '0;
                S_ADDR_H, S_CNT_H, S_DATA_H: begin
                    r_hi  <= bus.in_data;
                    r_chk <= r_chk ^ bus.in_data;
                end
                S_ADDR_L: begin
                    r_addr <= w_word[ADDR_W-1:0];
                    r_chk  <= r_chk ^ bus.in_data;
                end
                S_CNT_L: begin
                    r_cnt <= w_word;
                    r_chk <= r_chk ^ bus.in_data;
                end
                // Present address and data now so they are stable through the WRITE cycle
                S_DATA_L: begin
                    r_addra <= r_addr;
                    r_dia   <= w_word;
                    r_chk   <= r_chk ^ bus.in_data;
                end
                default: ;
            endcase
        end
    end
endmodule
